// File: rtl/vmem_arbiter.sv
// Single-owner port controller for the 16x16 video RAM: display, game port and clear engine.
// Optional build macro VMEM_CHECKER_CLEAR_EN makes the clear sweep write a checkerboard instead of zeros.
module vmem_arbiter #(
    parameter int unsigned CPU_MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       disp_req,
    input  logic [3:0] disp_x,
    input  logic [3:0] disp_y,
    output logic       disp_gnt,
    output logic       disp_rvalid,
    output logic       disp_rdata,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [3:0] cpu_x,
    input  logic [3:0] cpu_y,
    input  logic       cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_rvalid,
    output logic       cpu_rdata,
    input  logic       clr_start,
    output logic       clr_busy,
    output logic       clr_done,
    output logic [3:0] mem_x,
    output logic [3:0] mem_y,
    output logic       mem_we,
    output logic       mem_wdata,
    input  logic       mem_rdata
);

    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

    typedef enum logic {
        NORMAL,
        CLEAR
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] wait_q, wait_d;
    logic       disp_rvalid_q, disp_rvalid_d;
    logic       cpu_rvalid_q, cpu_rvalid_d;
    logic       clr_done_q, clr_done_d;
    logic       arb_en;
    logic       clr_wdata;

    // Grants only exist in NORMAL and never while reset is asserted.
    assign arb_en   = (state_q == NORMAL) && !rst;
    assign cpu_gnt  = arb_en && cpu_req && (!disp_req || (wait_q == MAX_WAIT));
    assign disp_gnt = arb_en && disp_req && !cpu_gnt;

`ifdef VMEM_CHECKER_CLEAR_EN
    assign clr_wdata = cnt_q[0] ^ cnt_q[4];
`else
    assign clr_wdata = 1'b0;
`endif

    always_comb begin
        mem_x     = '0;
        mem_y     = '0;
        mem_we    = 1'b0;
        mem_wdata = 1'b0;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_x     = cnt_q[3:0];
                mem_y     = cnt_q[7:4];
                mem_we    = 1'b1;
                mem_wdata = clr_wdata;
            end else if (cpu_gnt) begin
                mem_x     = cpu_x;
                mem_y     = cpu_y;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
            end else if (disp_gnt) begin
                mem_x = disp_x;
                mem_y = disp_y;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            NORMAL: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    state_d    = NORMAL;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = NORMAL;
        endcase

        // Refused cycles keep counting during a sweep, but grants stay blocked there.
        wait_d = wait_q;
        if (!cpu_req || cpu_gnt) begin
            wait_d = '0;
        end else if (wait_q != MAX_WAIT) begin
            wait_d = wait_q + 4'd1;
        end

        disp_rvalid_d = disp_gnt;
        cpu_rvalid_d  = cpu_gnt && !cpu_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NORMAL;
            cnt_q         <= '0;
            wait_q        <= '0;
            disp_rvalid_q <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            clr_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wait_q        <= wait_d;
            disp_rvalid_q <= disp_rvalid_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            clr_done_q    <= clr_done_d;
        end
    end

    assign clr_busy    = (state_q == CLEAR);
    assign clr_done    = clr_done_q;
    assign disp_rvalid = disp_rvalid_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign disp_rdata  = disp_rvalid_q & mem_rdata;
    assign cpu_rdata   = cpu_rvalid_q & mem_rdata;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Scoreboard bench for vmem_arbiter with a behavioural 16x16 RAM and a shadow copy of its contents.
module tb_vmem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       disp_req, disp_gnt, disp_rvalid, disp_rdata;
    logic [3:0] disp_x, disp_y;
    logic       cpu_req, cpu_we, cpu_wdata, cpu_gnt, cpu_rvalid, cpu_rdata;
    logic [3:0] cpu_x, cpu_y;
    logic       clr_start, clr_busy, clr_done;
    logic [3:0] mem_x, mem_y;
    logic       mem_we, mem_wdata, mem_rdata;

    logic ram    [0:255];
    logic shadow [0:255];
    logic disp_q [$];
    logic cpu_q  [$];
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    vmem_arbiter #(.CPU_MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_x(cpu_x), .cpu_y(cpu_y),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .clr_start(clr_start), .clr_busy(clr_busy),
        .clr_done(clr_done), .mem_x(mem_x), .mem_y(mem_y), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM model: synchronous write, read data one cycle after the address.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 1'((i ^ (i >> 3)) & 1);
        mem_rdata = 1'b0;
        forever begin
            @(posedge clk);
            mem_rdata <= ram[{mem_y, mem_x}];
            if (mem_we) ram[{mem_y, mem_x}] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_w(input int k);
`ifdef VMEM_CHECKER_CLEAR_EN
        return 1'((k ^ (k >> 4)) & 1);
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: pops expected read data whenever a read return is presented.
    initial forever begin
        @(negedge clk);
        if (disp_rvalid) begin
            if (disp_q.size() == 0) chk("disp_rvalid_stray", 1, 0);
            else                    chk("disp_rdata", disp_rdata, disp_q.pop_front());
        end else chk("disp_rdata_idle", disp_rdata, 0);
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) chk("cpu_rvalid_stray", 1, 0);
            else                   chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end else chk("cpu_rdata_idle", cpu_rdata, 0);
        chk("busy_done_excl", clr_busy & clr_done, 0);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic disp_read(input logic [3:0] x, input logic [3:0] y);
        disp_req = 1'b1; disp_x = x; disp_y = y;
        @(negedge clk);
        chk("disp_gnt", disp_gnt, 1);
        chk("disp_mem_drive", {mem_x, mem_y, mem_we}, {x, y, 1'b0});
        if (disp_gnt) disp_q.push_back(shadow[{y, x}]);
        nxt();
        disp_req = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [3:0] x, input logic [3:0] y, input logic d);
        cpu_req = 1'b1; cpu_we = we; cpu_x = x; cpu_y = y; cpu_wdata = d;
        @(negedge clk);
        chk("cpu_gnt", cpu_gnt, 1);
        if (we) chk("cpu_wr_drive", {mem_x, mem_y, mem_we, mem_wdata}, {x, y, 1'b1, d});
        else    chk("cpu_rd_drive", {mem_x, mem_y, mem_we}, {x, y, 1'b0});
        if (cpu_gnt) begin
            if (we) shadow[{y, x}] = d;
            else    cpu_q.push_back(shadow[{y, x}]);
        end
        nxt();
        cpu_req = 1'b0;
    endtask

    // Both ports contend; cpu_req drops for one cycle at drop_at; game port must win at gnt_at.
    task automatic contend(input int drop_at, input int gnt_at);
        disp_req = 1'b1; disp_x = 4'd3; disp_y = 4'd3;
        cpu_we = 1'b0; cpu_x = 4'd4; cpu_y = 4'd5;
        for (int i = 1; i <= gnt_at + 1; i++) begin
            cpu_req = (i != drop_at) && (i <= gnt_at);
            @(negedge clk);
            chk("contend_disp_gnt", disp_gnt, (i != gnt_at));
            chk("contend_cpu_gnt", cpu_gnt, (i == gnt_at));
            if (disp_gnt) disp_q.push_back(shadow[{4'd3, 4'd3}]);
            if (cpu_gnt)  cpu_q.push_back(shadow[{4'd5, 4'd4}]);
            nxt();
        end
        disp_req = 1'b0; cpu_req = 1'b0;
    endtask

    // Follows a running sweep; returns at the negedge of the first non-busy cycle.
    task automatic sweep(input int repulse_at);
        int k = 0;
        while (k < 300) begin
            clr_start = (k == repulse_at);
            @(negedge clk);
            if (!clr_busy) break;
            chk("clr_cycle", {disp_gnt, cpu_gnt, mem_we, mem_y, mem_x, mem_wdata},
                {2'b00, 1'b1, 8'(k), exp_w(k)});
            shadow[k] = exp_w(k);
            k++;
            nxt();
        end
        clr_start = 1'b0;
        chk("clr_busy_cycles", k, 256);
        chk("clr_done_pulse", clr_done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failed=%0d", failed);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 1'((i ^ (i >> 3)) & 1);
        rst = 1'b1; disp_req = 1'b1; disp_x = 4'd7; disp_y = 4'd7;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_x = 4'd2; cpu_y = 4'd2; cpu_wdata = 1'b1;
        clr_start = 1'b0;
        nxt();
        @(negedge clk);
        chk("rst_grants", {disp_gnt, cpu_gnt}, 0);
        chk("rst_outputs", {mem_x, mem_y, mem_we, mem_wdata, clr_busy, clr_done, disp_rvalid, cpu_rvalid}, 0);
        nxt();
        rst = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;

        disp_read(4'd1, 4'd2);
        cpu_access(1'b1, 4'd4, 4'd5, 1'b1);
        cpu_access(1'b0, 4'd4, 4'd5, 1'b0);
        contend(0, 5);
        contend(4, 9);

        for (int i = 0; i < 256; i++) cpu_access(1'b1, 4'(i), 4'(i >> 4), 1'b1);

        // Clear requested alongside a pending read: this cycle still arbitrates.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_x = 4'd15; cpu_y = 4'd15; clr_start = 1'b1;
        @(negedge clk);
        chk("clr_start_arb_gnt", cpu_gnt, 1);
        chk("clr_start_busy", clr_busy, 0);
        if (cpu_gnt) cpu_q.push_back(shadow[255]);
        nxt();
        clr_start = 1'b0; cpu_x = 4'd0; cpu_y = 4'd0;
        sweep(-1);
        chk("post_clr_cpu_gnt", cpu_gnt, 1);
        if (cpu_gnt) cpu_q.push_back(shadow[0]);
        nxt();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("clr_done_one_cycle", clr_done, 0);
        nxt();

        disp_read(4'd0, 4'd0);
        disp_read(4'd15, 4'd15);
        disp_read(4'd7, 4'd9);
        disp_read(4'd1, 4'd0);

        // Re-pulsed start mid-sweep is ignored.
        clr_start = 1'b1;
        nxt();
        clr_start = 1'b0;
        sweep(10);
        nxt();
        @(negedge clk);
        chk("repulse_no_restart", {clr_busy, clr_done}, 0);
        nxt();

        // Reset mid-sweep at cnt=100.
        cpu_access(1'b1, 4'd3, 4'd6, 1'b1);
        cpu_access(1'b1, 4'd4, 4'd6, 1'b1);
        clr_start = 1'b1;
        nxt();
        clr_start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        for (int i = 0; i < 100; i++) shadow[i] = exp_w(i);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_clr_drive", {mem_we, mem_wdata, mem_x, mem_y, disp_gnt, cpu_gnt}, 0);
        nxt();
        rst = 1'b0;
        disp_req = 1'b1; disp_x = 4'd5; disp_y = 4'd6;
        @(negedge clk);
        chk("abort_state", {clr_busy, clr_done}, 0);
        chk("abort_disp_gnt", disp_gnt, 1);
        if (disp_gnt) disp_q.push_back(shadow[{4'd6, 4'd5}]);
        nxt();
        disp_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {clr_busy, clr_done}, 0);
            nxt();
        end
        disp_read(4'd3, 4'd6);
        disp_read(4'd4, 4'd6);

        nxt();
        nxt();
        chk("disp_queue_drained", disp_q.size(), 0);
        chk("cpu_queue_drained", cpu_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
